serial_deserializer: RTL
========================

Name: serial_deserializer

Overview:
- Downstream companion of the universal shift register: consumes its serial output stream and rebuilds parallel words.
- Samples one bit per strobe and counts SIZE bits per word.
- Presents each completed word on a valid/ready output holding register.
- Flags a sticky overrun when a word completes while the previous word is still unconsumed.

Parameters:
SIZE, 8, word width in bits and bits per word; legal range is SIZE >= 2.
MSB_FIRST, 1, 1 places the first received bit in dataOut[SIZE-1], matching a left-shifting source whose serial output is its MSB; 0 places the first bit in dataOut[0].

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
serEn  input  1  bit strobe; serIn sampled on a rising edge where serEn=1
serIn  input  1  serial data bit
clear  input  1  synchronous abort: drops partial word, valid, and overrun
ready  input  1  consumer accepts dataOut when valid=1 and ready=1
dataOut  output  SIZE  last completed word (holding register)
valid  output  1  dataOut holds an unconsumed word
overrun  output  1  sticky; a completed word was dropped
bitCount  output  $clog2(SIZE+1)  bits collected in current partial word, 0..SIZE-1

Behaviour:
- Reset values (rst=1 at an edge): shift accumulator 0, bitCount 0, dataOut 0, valid 0, overrun 0. rst has priority over every other input.
- clear=1 (rst=0): same effect as reset on accumulator, bitCount, valid, and overrun; dataOut is retained. clear has priority over serEn and ready in that cycle.
- Bit capture on an edge with serEn=1:
  - MSB_FIRST=1: accumulator <= {acc[SIZE-2:0], serIn}.
  - MSB_FIRST=0: accumulator <= {serIn, acc[SIZE-1:1]}.
  - bitCount increments.
- serEn=0: accumulator and bitCount hold.
- Word completion: the edge where serEn=1 and bitCount==SIZE-1.
  - The assembled word, including the current serIn, goes to the holding register on that same edge.
  - valid=1 and dataOut are visible the cycle after the last bit edge (latency 1 edge).
  - bitCount wraps to 0 and the accumulator clears.
  - Completion with no stall: back-to-back words with serEn held high every cycle are supported.
- Handshake: an edge with valid=1 and ready=1 consumes the word, so valid drops to 0 unless a completion occurs on the same edge. ready is ignored when valid=0. dataOut is stable while valid=1 and ready=0.
- Simultaneous completion and consume (valid=1, ready=1): the new word loads, valid stays 1, and there is no overrun.
- Completion while valid=1 and ready=0:
  - The new word is dropped and dataOut keeps the old word.
  - overrun sets to 1 and stays 1 until rst or clear.
  - bitCount still wraps to 0, keeping word alignment.
- Completion while valid=0: load the word, valid=1.
- rst or clear mid-word: partial bits are discarded and the next serEn bit is bit 0 of a new word.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then serEn=0 for 10 cycles -> dataOut=0x00, valid=0, overrun=0, bitCount=0 throughout.
- Single word, MSB_FIRST=1, SIZE=8, ready=1: serEn=1 for 8 cycles with serIn bits 1,0,1,0,0,1,0,1 -> one cycle after the 8th edge, dataOut=0xA5 and valid=1 for exactly 1 cycle; bitCount counts 1..7 then 0.
- LSB-first (MSB_FIRST=0): same bit sequence -> dataOut=0xA5 (bit order 1,0,1,0,0,1,0,1 read as LSB..MSB).
- Backpressure and overrun, ready=0: send 0x3C then 0xC3 back-to-back -> dataOut stays 0x3C, valid=1, overrun=1 from the cycle after the 16th bit. Then assert ready=1 for 1 cycle -> valid=0, overrun stays 1. Then clear -> overrun=0.
- Simultaneous consume and complete, ready=1 only on the edge where the 2nd word (0x0F) completes, first word 0xF0 pending -> dataOut=0x0F, valid remains 1, overrun=0.
- Abort mid-word: 3 bits sent, clear=1 for 1 cycle, then 8 bits of 0x81 -> dataOut=0x81 with no contamination and bitCount=0 after clear. Repeat the same sequence with rst instead of clear -> identical word, dataOut reset to 0x00 before it.

Source files
------------

// File: rtl/serial_deserializer.sv
// Rebuilds SIZE-bit parallel words from a strobed serial stream and presents
// each finished word in a valid/ready holding register with a sticky overrun flag.
module serial_deserializer #(
  parameter int SIZE      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_serEn,
  input  logic                      i_serIn,
  input  logic                      i_clear,
  input  logic                      i_ready,
  output logic [SIZE-1:0]           o_dataOut,
  output logic                      o_valid,
  output logic                      o_overrun,
  output logic [$clog2(SIZE+1)-1:0] o_bitCount
);

  localparam int CW = $clog2(SIZE + 1);

  logic [SIZE-1:0] r_acc;
  logic [CW-1:0]   r_count;
  logic [SIZE-1:0] r_data;
  logic            r_valid;
  logic            r_overrun;

  logic [SIZE-1:0] w_nextAcc;
  logic            w_lastBit;
  logic            w_consume;

  // Shift direction decides whether the first bit lands in the MSB or the LSB.
  generate
    if (MSB_FIRST) begin : g_msbFirst
      assign w_nextAcc = {r_acc[SIZE-2:0], i_serIn};
    end else begin : g_lsbFirst
      assign w_nextAcc = {i_serIn, r_acc[SIZE-1:1]};
    end
  endgenerate

  assign w_lastBit = i_serEn && (r_count == CW'(SIZE - 1));
  assign w_consume = r_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc     <= '0;
      r_count   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (i_clear) begin
      r_acc     <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_lastBit) begin
        r_acc   <= '0;
        r_count <= '0;
      end else if (i_serEn) begin
        r_acc   <= w_nextAcc;
        r_count <= r_count + CW'(1);
      end

      // A finished word only loads if the slot is free or being drained this edge.
      if (w_lastBit) begin
        if (!r_valid || i_ready) begin
          r_data  <= w_nextAcc;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_dataOut  = r_data;
  assign o_valid    = r_valid;
  assign o_overrun  = r_overrun;
  assign o_bitCount = r_count;

endmodule
